// File: rtl/ac_ph_sched_pkg.sv
// Shared types and helpers for the AC_PH frame scheduler slice.
// Holds the FSM state enum, default widths and the rotating-priority search.
package ac_ph_sched_pkg;

  localparam int DEF_CHANELS      = 4;
  localparam int DEF_FRAME_LENGTH = 360;
  localparam int CH_W             = $clog2(DEF_CHANELS);
  localparam int ADDR_W           = $clog2(DEF_FRAME_LENGTH);
  localparam int MAX_CH           = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
  } rr_gnt_t;

  // First set bit of req at or above ptr, wrapping modulo n.
  function automatic rr_gnt_t rr_search(
    input logic [MAX_CH-1:0] req,
    input int unsigned       ptr,
    input int unsigned       n
  );
    rr_gnt_t     g;
    int unsigned j;
    g = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      j = (ptr + i) % n;
      if (i < n && !g.vld && req[5'(j)]) begin
        g.vld = 1'b1;
        g.idx = 8'(j);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ac_ph_frame_scheduler_rr_arbiter.sv
// Combinational round-robin picker: req, ptr -> gnt_valid, gnt_idx.
// Also used by the result-side channel distributor.
module rr_arbiter
  import ac_ph_sched_pkg::*;
#(
  parameter int N = DEF_CHANELS,
  parameter int W = CH_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [MAX_CH-1:0] req_ext;
  rr_gnt_t           g;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    g              = rr_search(req_ext, 32'(ptr), 32'(N));
    gnt_valid      = g.vld;
    gnt_idx        = W'(g.idx);
  end

endmodule

// File: rtl/ac_ph_frame_scheduler.sv
// Round-robin frame scheduler feeding the shared AC_PH engine, credit limited.
// Ports: clk/rstn, enable, ch_req/ch_ack, rd_* buffer port, eng_* stream, res_vld, busy/inflight/err.
module ac_ph_frame_scheduler
  import ac_ph_sched_pkg::*;
#(
  parameter int CHANELS      = DEF_CHANELS,
  parameter int FRAME_LENGTH = DEF_FRAME_LENGTH,
  parameter int X_WIDTH      = 16,
  parameter int MAX_INFLIGHT = 3,
  parameter int GAP_CYCLES   = 2,
  localparam int CW = $clog2(CHANELS),
  localparam int AW = $clog2(FRAME_LENGTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic [CHANELS-1:0] ch_req,
  output logic [CHANELS-1:0] ch_ack,
  output logic               rd_en,
  output logic [CW-1:0]      rd_chan,
  output logic [AW-1:0]      rd_addr,
  input  logic [X_WIDTH-1:0] rd_x1,
  input  logic [X_WIDTH-1:0] rd_x2,
  output logic               eng_vld,
  output logic [X_WIDTH-1:0] eng_x1,
  output logic [X_WIDTH-1:0] eng_x2,
  output logic [CW-1:0]      eng_chan,
  input  logic               res_vld,
  output logic               busy,
  output logic [2:0]         inflight,
  output logic               err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] LAST    = AW'(FRAME_LENGTH - 1);
  localparam logic [AW-1:0] LAST_M1 = AW'(FRAME_LENGTH - 2);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANELS - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_CYCLES - 1);

  sched_state_t  state;
  logic [CW-1:0] rr_ptr;
  logic [GW-1:0] gap_cnt;
  logic          rd_en_d;
  logic          gnt_valid;
  logic [CW-1:0] gnt_idx;
  logic          grant;
  logic          res_ok;

  rr_arbiter #(
    .N (CHANELS),
    .W (CW)
  ) u_arb (
    .req       (ch_req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    grant  = (state == ARB) && enable && gnt_valid
             && (inflight < 3'(MAX_INFLIGHT));
    res_ok = res_vld && (inflight != 3'd0);
  end

  assign busy = (state != IDLE) || (inflight != 3'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      inflight <= 3'd0;
      err      <= 1'b0;
      ch_ack   <= '0;
      rd_en    <= 1'b0;
      rd_chan  <= '0;
      rd_addr  <= '0;
      rd_en_d  <= 1'b0;
      eng_vld  <= 1'b0;
      eng_x1   <= '0;
      eng_x2   <= '0;
      eng_chan <= '0;
    end else begin
      ch_ack  <= '0;
      rd_en_d <= rd_en;
      eng_vld <= rd_en_d;
      if (rd_en_d) begin
        eng_x1 <= rd_x1;
        eng_x2 <= rd_x2;
      end

      // grant and result in the same cycle cancel out
      if (grant && !res_ok) begin
        inflight <= inflight + 3'd1;
      end else if (!grant && res_ok) begin
        inflight <= inflight - 3'd1;
      end
      if (res_vld && inflight == 3'd0) begin
        err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (enable) state <= ARB;
        end
        ARB: begin
          if (!enable) begin
            state <= IDLE;
          end else if (grant) begin
            state    <= STREAM;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            rd_chan  <= gnt_idx;
            eng_chan <= gnt_idx;
            rr_ptr   <= (gnt_idx == CH_LAST) ? '0 : gnt_idx + 1'b1;
            if (FRAME_LENGTH == 1) begin
              ch_ack <= CHANELS'(1) << gnt_idx;
            end
          end
        end
        STREAM: begin
          if (rd_addr == LAST) begin
            rd_en   <= 1'b0;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES == 0) ? ARB : GAP;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            // ack lines up with the final read strobe
            if (FRAME_LENGTH > 1 && rd_addr == LAST_M1) begin
              ch_ack <= CHANELS'(1) << rd_chan;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            state <= ARB;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_ph_frame_scheduler.sv
// Scoreboard bench for ac_ph_frame_scheduler with a timestamp-based reference.
// Expected reads, engine samples and acks are queued at grant time.
module tb_ac_ph_frame_scheduler;

  localparam int NCH = 4;
  localparam int FL  = 8;
  localparam int XW  = 16;
  localparam int MI  = 3;
  localparam int GC  = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic           enable;
  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_ack;
  logic           rd_en;
  logic [1:0]     rd_chan;
  logic [2:0]     rd_addr;
  logic [XW-1:0]  rd_x1;
  logic [XW-1:0]  rd_x2;
  logic           eng_vld;
  logic [XW-1:0]  eng_x1;
  logic [XW-1:0]  eng_x2;
  logic [1:0]     eng_chan;
  logic           res_vld;
  logic           busy;
  logic [2:0]     inflight;
  logic           err;

  logic res_man;
  logic res_auto;
  logic auto_on;
  logic chk_on;
  assign res_vld = res_man | res_auto;

  always #5 clk = ~clk;

  ac_ph_frame_scheduler #(
    .CHANELS      (NCH),
    .FRAME_LENGTH (FL),
    .X_WIDTH      (XW),
    .MAX_INFLIGHT (MI),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .ch_req   (ch_req),
    .ch_ack   (ch_ack),
    .rd_en    (rd_en),
    .rd_chan  (rd_chan),
    .rd_addr  (rd_addr),
    .rd_x1    (rd_x1),
    .rd_x2    (rd_x2),
    .eng_vld  (eng_vld),
    .eng_x1   (eng_x1),
    .eng_x2   (eng_x2),
    .eng_chan (eng_chan),
    .res_vld  (res_vld),
    .busy     (busy),
    .inflight (inflight),
    .err      (err)
  );

  function automatic logic [XW-1:0] bx1(input int c, input int a);
    return XW'((c << 8) | a | 32'h1000);
  endfunction

  // frame buffers: data one cycle after the read, garbage otherwise
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x1 <= bx1(int'(rd_chan), int'(rd_addr));
      rd_x2 <= ~bx1(int'(rd_chan), int'(rd_addr));
    end else begin
      rd_x1 <= XW'($urandom);
      rd_x2 <= XW'($urandom);
    end
  end

  typedef struct { int cyc; int ch; int addr; } rd_t;
  typedef struct { int cyc; int x1; int x2; } eg_t;
  typedef struct { int cyc; int ch; } ak_t;

  rd_t rd_q[$];
  eg_t eg_q[$];
  ak_t ak_q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  bit m_idle = 1;
  int m_next = 0;
  int m_rr = 0;
  int m_cnt = 0;
  bit m_err = 0;
  int m_engch = 0;

  // reference: a frame granted at edge P owns reads P..P+FL-1 and
  // the next arbitration happens at edge P+FL+GC+1
  always @(posedge clk) begin
    bit g;
    int gc;
    cyc++;
    if (!rstn) begin
      m_idle = 1; m_next = 0; m_rr = 0;
      m_cnt = 0; m_err = 0; m_engch = 0;
      rd_q.delete(); eg_q.delete(); ak_q.delete();
    end else begin
      g = 0;
      gc = 0;
      if (m_idle) begin
        if (enable) begin
          m_idle = 0;
          m_next = cyc + 1;
        end
      end else if (cyc == m_next) begin
        if (!enable) begin
          m_idle = 1;
        end else if (ch_req != 0 && m_cnt < MI) begin
          for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (!g && ch_req[c]) begin
              g = 1;
              gc = c;
            end
          end
          for (int k = 0; k < FL; k++) begin
            rd_q.push_back('{cyc + k, gc, k});
            eg_q.push_back('{cyc + k + 2, int'(bx1(gc, k)),
                             int'(XW'(~bx1(gc, k)))});
          end
          ak_q.push_back('{cyc + FL - 1, gc});
          m_rr = (gc + 1) % NCH;
          m_engch = gc;
          m_next = cyc + FL + GC + 1;
        end else begin
          m_next = cyc + 1;
        end
      end
      if (res_vld && m_cnt == 0) m_err = 1;
      m_cnt = m_cnt + (g ? 1 : 0) - ((res_vld && m_cnt > 0) ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit er;
      bit ee;
      logic [NCH-1:0] ea;
      er = rd_q.size() > 0 && rd_q[0].cyc == cyc;
      chk("rd_en", 32'(rd_en), 32'(er));
      if (er) begin
        if (rd_en === 1'b1) begin
          chk("rd_chan", 32'(rd_chan), 32'(rd_q[0].ch));
          chk("rd_addr", 32'(rd_addr), 32'(rd_q[0].addr));
        end
        void'(rd_q.pop_front());
      end
      ee = eg_q.size() > 0 && eg_q[0].cyc == cyc;
      chk("eng_vld", 32'(eng_vld), 32'(ee));
      if (ee) begin
        if (eng_vld === 1'b1) begin
          chk("eng_x1", 32'(eng_x1), 32'(eg_q[0].x1));
          chk("eng_x2", 32'(eng_x2), 32'(eg_q[0].x2));
        end
        void'(eg_q.pop_front());
      end
      ea = '0;
      if (ak_q.size() > 0 && ak_q[0].cyc == cyc) begin
        ea[ak_q[0].ch] = 1'b1;
        void'(ak_q.pop_front());
      end
      chk("ch_ack", 32'(ch_ack), 32'(ea));
      chk("inflight", 32'(inflight), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(!m_idle || m_cnt != 0));
      chk("eng_chan", 32'(eng_chan), 32'(m_engch));
    end
  end

  // engine stand-in: one result per FL engine samples, random latency
  int ecnt = 0;
  int pend = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      ecnt = 0;
      pend = 0;
      res_auto = 1'b0;
    end else begin
      if (eng_vld === 1'b1) begin
        ecnt++;
        if (ecnt == FL) begin
          ecnt = 0;
          pend++;
        end
      end
      res_auto = 1'b0;
      if (auto_on && pend > 0 && $urandom_range(0, 3) == 0) begin
        res_auto = 1'b1;
        pend--;
      end
    end
  end

  task automatic wait_rd(input int a, input string nm);
    int n;
    n = 0;
    while (!(rd_en === 1'b1 && int'(rd_addr) == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout %s waited=%0d cycles", nm, n);
    end
  endtask

  task automatic pulse_res();
    res_man = 1'b1;
    @(negedge clk);
    res_man = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; enable = 1'b0; ch_req = '0;
    res_man = 1'b0; auto_on = 1'b0; chk_on = 1'b0;
    @(posedge clk);
    @(posedge clk);
    chk_on = 1'b1;
    idle(2);
    rstn = 1'b1;
    idle(2);

    // single request on channel 2
    enable = 1'b1;
    ch_req = 4'b0100;
    wait_rd(0, "single");
    ch_req = '0;
    idle(20);
    pulse_res();
    idle(5);

    // round robin with prompt results
    auto_on = 1'b1;
    ch_req = 4'b1111;
    idle(90);
    ch_req = '0;
    idle(60);

    // credit stall then a single release
    auto_on = 1'b0;
    ch_req = 4'b1111;
    idle(60);
    pulse_res();
    idle(20);
    ch_req = '0;
    auto_on = 1'b1;
    idle(100);

    // spurious result at inflight 0
    enable = 1'b0;
    idle(5);
    pulse_res();
    idle(5);

    // enable dropped mid-frame
    auto_on = 1'b0;
    enable = 1'b1;
    ch_req = 4'b0010;
    wait_rd(3, "enable_drop");
    enable = 1'b0;
    idle(30);

    // reset mid-frame
    enable = 1'b1;
    ch_req = 4'b1010;
    wait_rd(5, "mid_reset");
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    idle(30);

    // randomized traffic
    auto_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) ch_req = NCH'($urandom);
      enable = ($urandom_range(0, 31) != 0);
      res_man = ($urandom_range(0, 99) == 0);
      rstn = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    res_man = 1'b0;
    rstn = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ac_ph_frame_scheduler.md
Name: ac_ph_frame_scheduler

Overview:
- Sequences the shared AC_PH engine across CHANELS input channels.
- Round-robin arbitration picks one channel whose frame buffer holds a complete frame, then streams FRAME_LENGTH (x1, x2) sample pairs from that buffer into the engine.
- Limits the number of frames issued but not yet reported by the engine to MAX_INFLIGHT, so the downstream channel-address FIFO (depth 3) can never overflow.
- Tags each issued frame with its channel number for the result path.

Parameters:
- CHANELS, 4, number of channel frame buffers; must be >= 2.
- FRAME_LENGTH, 360, sample pairs per frame.
- X_WIDTH, 16, sample width.
- MAX_INFLIGHT, 3, maximum frames issued whose result is not yet reported; range 1..7.
- GAP_CYCLES, 2, idle cycles forced between frames; 0 is allowed.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- enable  in  1  permits new frame grants; a frame already in progress always completes.
- ch_req  in  CHANELS  per-channel "complete frame ready" level.
- ch_ack  out  CHANELS  one-hot, 1-cycle pulse that releases the buffer of the channel just read.
- rd_en  out  1  buffer read strobe.
- rd_chan  out  $clog2(CHANELS)  buffer select.
- rd_addr  out  $clog2(FRAME_LENGTH)  sample index.
- rd_x1  in  X_WIDTH  buffer data; valid 1 cycle after rd_en.
- rd_x2  in  X_WIDTH  buffer data; valid 1 cycle after rd_en.
- eng_vld  out  1  sample strobe to the engine.
- eng_x1  out  X_WIDTH  registered sample to the engine.
- eng_x2  out  X_WIDTH  registered sample to the engine.
- eng_chan  out  $clog2(CHANELS)  channel of the frame in flight; held for the whole frame.
- res_vld  in  1  one pulse per frame result from the engine.
- busy  out  1  high whenever state != IDLE or inflight != 0.
- inflight  out  3  count of outstanding frames.
- err  out  1  sticky flag: res_vld arrived while inflight == 0.

Behaviour:
- Reset (rstn = 0 at a clk edge): state = IDLE, rr_ptr = 0, inflight = 0, all strobes and pulses = 0, rd_chan/rd_addr/eng_x*/eng_chan = 0, err = 0. Reset mid-frame abandons the frame and issues no ch_ack.
- States: IDLE, ARB, STREAM, GAP.
  - IDLE -> ARB when enable = 1.
  - ARB -> STREAM when enable = 1, ch_req != 0 and inflight < MAX_INFLIGHT. Otherwise stay in ARB; if enable = 0, go to IDLE.
  - STREAM -> GAP after the rd_en with rd_addr = FRAME_LENGTH-1. If GAP_CYCLES = 0, go directly to ARB.
  - GAP -> ARB after GAP_CYCLES cycles.
- Arbitration (in ARB only): grant the first channel with ch_req set, searching from rr_ptr upward with wrap. On grant:
  - rd_chan and eng_chan <= granted channel.
  - rr_ptr <= granted + 1, wrapping CHANELS-1 -> 0.
  - inflight increments.
- STREAM:
  - rd_en = 1 every cycle; rd_addr runs 0..FRAME_LENGTH-1 with no bubbles.
  - First rd_en occurs in the cycle after the grant.
  - ch_ack[chan] pulses in the same cycle as the last rd_en.
- Data path: a read issued in cycle t gives eng_vld, eng_x1 = rd_x1 and eng_x2 = rd_x2 registered in cycle t+2. Each frame therefore produces exactly FRAME_LENGTH contiguous eng_vld pulses.
- inflight counter:
  - +1 on grant, -1 on res_vld.
  - Both in the same cycle: unchanged.
  - res_vld with inflight = 0: counter stays 0 and err is set.
  - The counter never exceeds MAX_INFLIGHT.
- ch_req is sampled only in ARB; changes during STREAM or GAP are ignored.
- enable = 0 during STREAM: the frame finishes, GAP is taken, then ARB moves to IDLE.
- Back-to-back frames: the minimum period is 1 + FRAME_LENGTH + GAP_CYCLES cycles per frame.

Decomposition:
- Package ac_ph_sched_pkg holds:
  - state enum sched_state_t {IDLE, ARB, STREAM, GAP};
  - CH_W = $clog2(CHANELS), ADDR_W = $clog2(FRAME_LENGTH);
  - a localparam function for the rotating priority search.
- One sub-module, rr_arbiter: combinational inputs req and ptr, outputs gnt_valid and gnt_idx. It is reused by the result-side channel distributor.

Test Plan (bench params CHANELS=4, FRAME_LENGTH=8, GAP_CYCLES=2, MAX_INFLIGHT=3):
- Single request: ch_req = 4'b0100, enable = 1, buffer returns x1 = addr, x2 = ~addr → rd_addr 0..7 on rd_chan = 2; eng_vld for 8 cycles with eng_x1 = 0..7, starting 2 cycles after the first rd_en; ch_ack = 4'b0100 with the last read; inflight = 1.
- Round-robin: ch_req = 4'b1111 held, res_vld returned promptly → grant order 0, 1, 2, 3, 0; frame starts 11 cycles apart.
- Credit stall: ch_req = 4'b1111, no res_vld → exactly 3 frames issued, then the block sits in ARB with inflight = 3. One res_vld pulse → the fourth frame (channel 3) starts on the next ARB evaluation.
- Simultaneous events: res_vld in the grant cycle with inflight = 3→ no grant (full); res_vld in the grant cycle with inflight = 2 → inflight stays 2. A spurious res_vld at inflight = 0 → err = 1 and stays set.
- enable dropped at rd_addr = 3 → the frame completes all 8 reads and its ch_ack, then IDLE with no new grant even though ch_req != 0.
- rstn = 0 at rd_addr = 5 → the next cycle shows rd_en = 0, no ch_ack, inflight = 0, rr_ptr = 0. After release, the first grant goes to the lowest requesting channel.
